// File: rtl/axilite_if.sv
// AXI4-Lite bus bundle: AW, W, B, AR and R channels with master/slave views.
interface axilite_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [STROBE_WIDTH-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axilite_reg_bank.sv
// Terminating AXI4-Lite slave holding NUM_REGS control registers.
// Independent write and read FSMs; one outstanding transaction per direction.
// Register contents are exported flat, with a one-cycle write pulse per register.
module axilite_reg_bank #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  axilite_if.slave                     s_axilite,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]          wr_pulse
);
  localparam int STROBE_WIDTH = DATA_WIDTH / 8;
  localparam int LSB          = $clog2(STROBE_WIDTH);

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]     wr_pulse_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STROBE_WIDTH-1:0] wstrb_q;
  logic [1:0]              bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                    aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [ADDR_WIDTH-1:0]   w_addr_s, w_idx_s, r_idx_s;
  logic [DATA_WIDTH-1:0]   w_data_s, rd_val_s;
  logic [STROBE_WIDTH-1:0] w_strb_s;
  logic                    w_in_range_s, r_in_range_s;

  // Readies are gated by reset so nothing is accepted while the bank clears.
  assign s_axilite.awready = ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_W)) && !rst;
  assign s_axilite.wready  = ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW)) && !rst;
  assign s_axilite.arready = (r_state_q == R_IDLE) && !rst;
  assign s_axilite.bvalid  = (w_state_q == W_RESP);
  assign s_axilite.bresp   = bresp_q;
  assign s_axilite.rvalid  = (r_state_q == R_RESP);
  assign s_axilite.rdata   = rdata_q;
  assign s_axilite.rresp   = rresp_q;

  assign aw_hs_s = s_axilite.awvalid && s_axilite.awready;
  assign w_hs_s  = s_axilite.wvalid && s_axilite.wready;
  assign ar_hs_s = s_axilite.arvalid && s_axilite.arready;

  // A channel that arrived earlier is taken from its holding register.
  assign w_addr_s     = (w_state_q == W_HAVE_AW) ? awaddr_q : s_axilite.awaddr;
  assign w_data_s     = (w_state_q == W_HAVE_W) ? wdata_q : s_axilite.wdata;
  assign w_strb_s     = (w_state_q == W_HAVE_W) ? wstrb_q : s_axilite.wstrb;
  assign w_idx_s      = w_addr_s >> LSB;
  assign w_in_range_s = (w_idx_s < ADDR_WIDTH'(NUM_REGS));
  assign r_idx_s      = s_axilite.araddr >> LSB;
  assign r_in_range_s = (r_idx_s < ADDR_WIDTH'(NUM_REGS));

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end
  assign wr_pulse = wr_pulse_q;

  // Write FSM next state, commit decision and response code.
  always_comb begin
    w_state_d = w_state_q;
    commit_s  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          w_state_d = W_RESP;
          commit_s  = 1'b1;
        end else if (aw_hs_s) begin
          w_state_d = W_HAVE_AW;
        end else if (w_hs_s) begin
          w_state_d = W_HAVE_W;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_HAVE_AW: begin
        if (w_hs_s) begin
          w_state_d = W_RESP;
          commit_s  = 1'b1;
        end else begin
          w_state_d = W_HAVE_AW;
        end
      end
      W_HAVE_W: begin
        if (aw_hs_s) begin
          w_state_d = W_RESP;
          commit_s  = 1'b1;
        end else begin
          w_state_d = W_HAVE_W;
        end
      end
      W_RESP: begin
        if (s_axilite.bready) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit_s) begin
      bresp_d = w_in_range_s ? 2'b00 : 2'b10;
    end else begin
      bresp_d = bresp_q;
    end
  end

  // Read FSM next state; data and response are captured at the AR handshake.
  always_comb begin
    r_state_d = r_state_q;
    rd_val_s  = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      rd_val_s = (r_idx_s == ADDR_WIDTH'(k)) ? regs_q[k] : rd_val_s;
    end
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_d = R_RESP;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_RESP: begin
        if (s_axilite.rready) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_RESP;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (ar_hs_s) begin
      rdata_d = r_in_range_s ? rd_val_s : {DATA_WIDTH{1'b0}};
      rresp_d = r_in_range_s ? 2'b00 : 2'b10;
    end else begin
      rdata_d = rdata_q;
      rresp_d = rresp_q;
    end
  end

  // State, held channel payloads and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      if (aw_hs_s) begin
        awaddr_q <= s_axilite.awaddr;
      end
      if (w_hs_s) begin
        wdata_q <= s_axilite.wdata;
        wstrb_q <= s_axilite.wstrb;
      end
    end
  end

  // Register array: byte-strobed update and single-cycle write pulse on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pulse_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      wr_pulse_q <= '0;
      if (commit_s && w_in_range_s) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (w_idx_s == ADDR_WIDTH'(k)) begin
            wr_pulse_q[k] <= 1'b1;
            for (int b = 0; b < STROBE_WIDTH; b++) begin
              if (w_strb_s[b]) begin
                regs_q[k][b*8 +: 8] <= w_data_s[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_axilite_reg_bank.sv
// Directed self-checking bench for axilite_reg_bank (NUM_REGS=16, 32-bit data).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axilite_reg_bank;
  localparam int NR = 16;
  localparam int AW = 32;
  localparam int DW = 32;

  logic               clk;
  logic               rst;
  logic [NR*DW-1:0]   regs_out;
  logic [NR-1:0]      wr_pulse;
  int                 errors;
  int                 checks;

  axilite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axilite_reg_bank #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axilite (bus),
    .regs_out  (regs_out),
    .wr_pulse  (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_at(input int k);
    return regs_out[k*DW +: DW];
  endfunction

  task automatic idle_inputs();
    bus.awvalid = 1'b0; bus.awaddr = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0;
    bus.rready  = 1'b0;
  endtask

  // Simultaneous AW+W, then check B response and pulse, then release bready.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp,
                          input logic [NR-1:0] exp_pulse);
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = addr;
    bus.wvalid  = 1'b1; bus.wdata  = data; bus.wstrb = strb;
    for (int i = 0; i < 20; i++) begin
      if (!(bus.awready && bus.wready)) @(negedge clk);
    end
    check_eq("wr_accept", {63'd0, bus.awready && bus.wready}, 64'd1);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check_eq("wr_bvalid", {63'd0, bus.bvalid}, 64'd1);
    check_eq("wr_bresp", {62'd0, bus.bresp}, {62'd0, exp_resp});
    check_eq("wr_pulse", {48'd0, wr_pulse}, {48'd0, exp_pulse});
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check_eq("wr_bvalid_clr", {63'd0, bus.bvalid}, 64'd0);
    check_eq("wr_pulse_clr", {48'd0, wr_pulse}, 64'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                         input logic [1:0] exp_resp);
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = addr;
    for (int i = 0; i < 20; i++) begin
      if (!bus.arready) @(negedge clk);
    end
    check_eq("rd_accept", {63'd0, bus.arready}, 64'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check_eq("rd_rvalid", {63'd0, bus.rvalid}, 64'd1);
    check_eq("rd_rdata", {32'd0, bus.rdata}, {32'd0, exp_data});
    check_eq("rd_rresp", {62'd0, bus.rresp}, {62'd0, exp_resp});
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check_eq("rd_rvalid_clr", {63'd0, bus.rvalid}, 64'd0);
  endtask

  logic [NR*DW-1:0] snap;

  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    rst = 1'b1;

    // Reset then idle.
    repeat (3) @(negedge clk);
    check_eq("rst_awready", {63'd0, bus.awready}, 64'd0);
    check_eq("rst_wready", {63'd0, bus.wready}, 64'd0);
    check_eq("rst_arready", {63'd0, bus.arready}, 64'd0);
    check_eq("rst_regs", {63'd0, |regs_out}, 64'd0);
    check_eq("rst_bvalid", {63'd0, bus.bvalid}, 64'd0);
    check_eq("rst_rvalid", {63'd0, bus.rvalid}, 64'd0);
    check_eq("rst_rdata", {32'd0, bus.rdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'd7);

    // Write then read register 2.
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0004);
    check_eq("reg2_val", {32'd0, reg_at(2)}, 64'hDEADBEEF);
    do_read(32'h08, 32'hDEADBEEF, 2'b00);

    // Decoupled order: W three cycles ahead of AW, partial strobe.
    do_write(32'h0C, 32'hAABBCCDD, 4'hF, 2'b00, 16'h0008);
    @(negedge clk);
    bus.wvalid = 1'b1; bus.wdata = 32'h11223344; bus.wstrb = 4'h5;
    @(negedge clk);
    bus.wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("hw_wready", {63'd0, bus.wready}, 64'd0);
      check_eq("hw_awready", {63'd0, bus.awready}, 64'd1);
      check_eq("hw_bvalid", {63'd0, bus.bvalid}, 64'd0);
      @(negedge clk);
    end
    bus.awvalid = 1'b1; bus.awaddr = 32'h0C;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check_eq("dec_awready", {63'd0, bus.awready}, 64'd0);
    check_eq("dec_bvalid", {63'd0, bus.bvalid}, 64'd1);
    check_eq("dec_pulse", {48'd0, wr_pulse}, 64'h0008);
    check_eq("reg3_merge", {32'd0, reg_at(3)}, 64'hAA22CC44);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;

    // Out of range.
    snap = regs_out;
    do_write(32'h40, 32'h12345678, 4'hF, 2'b10, 16'h0000);
    check_eq("oor_regs_kept", {63'd0, regs_out == snap}, 64'd1);
    do_read(32'h40, 32'h0, 2'b10);

    // Back-pressure on both channels.
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = 32'h10;
    bus.wvalid  = 1'b1; bus.wdata  = 32'h0BADF00D; bus.wstrb = 4'hF;
    bus.arvalid = 1'b1; bus.araddr = 32'h08;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_bvalid", {63'd0, bus.bvalid}, 64'd1);
      check_eq("bp_bresp", {62'd0, bus.bresp}, 64'd0);
      check_eq("bp_wreadies", {62'd0, bus.awready, bus.wready}, 64'd0);
      check_eq("bp_rvalid", {63'd0, bus.rvalid}, 64'd1);
      check_eq("bp_rdata", {32'd0, bus.rdata}, 64'hDEADBEEF);
      check_eq("bp_arready", {63'd0, bus.arready}, 64'd0);
      @(negedge clk);
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    check_eq("bp_idle_readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'd7);
    check_eq("bp_idle_valids", {62'd0, bus.bvalid, bus.rvalid}, 64'd0);
    check_eq("reg4_val", {32'd0, reg_at(4)}, 64'h0BADF00D);

    // Same-edge read and write of register 1: read sees the old value.
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = 32'h04;
    bus.wvalid  = 1'b1; bus.wdata  = 32'h5; bus.wstrb = 4'hF;
    bus.arvalid = 1'b1; bus.araddr = 32'h04;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check_eq("same_rvalid", {63'd0, bus.rvalid}, 64'd1);
    check_eq("same_rdata_old", {32'd0, bus.rdata}, 64'd0);
    check_eq("same_bvalid", {63'd0, bus.bvalid}, 64'd1);
    check_eq("reg1_new", {32'd0, reg_at(1)}, 64'd5);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0; bus.rready = 1'b0;

    // Reset while holding an AW: transaction dropped, registers cleared.
    bus.awvalid = 1'b1; bus.awaddr = 32'h14;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check_eq("haw_readies", {62'd0, bus.awready, bus.wready}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_regs", {63'd0, |regs_out}, 64'd0);
    check_eq("mid_rst_bvalid", {63'd0, bus.bvalid}, 64'd0);
    bus.wvalid = 1'b1; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF;
    @(negedge clk);
    bus.wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("post_rst_no_b", {63'd0, bus.bvalid}, 64'd0);
      check_eq("post_rst_regs", {63'd0, |regs_out}, 64'd0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
